mealy_stream_ctrl: RTL

- Controller that serialises parallel words into a 2-bit-state Mealy sequence detector, one bit per clock, MSB first.
- The detector flags overlapping "101". The controller counts detections per word and returns the count through a valid/ready result port.
- Sits between a word-level producer and the bit-level Mealy datapath, sequencing its input w and owning its state register (y1,y2).

---
 rtl/mealy_stream_ctrl_pkg.sv | 35 +++
 rtl/mealy_stream_ctrl_101_core.sv | 33 +++
 rtl/mealy_stream_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mealy_stream_ctrl_pkg.sv
// Shared types and constants for the word-to-bit "101" detector controller.
// Detector encoding, controller states and the default widths live here.
package mealy_stream_ctrl_pkg;

   localparam int DEF_WORD_W = 8;
   localparam int DEF_CNT_W  = 4;

   typedef enum logic [1:0] {
      S0 = 2'b00,
      S1 = 2'b01,
      S2 = 2'b10
   } det_state_e;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SHIFT  = 2'b01,
      REPORT = 2'b10
   } ctrl_state_e;

   // Returns {y_next, z}; the unused 11 encoding falls back to S0.
   function automatic logic [2:0] det_step(
      input logic [1:0] y,
      input logic       w
   );
      logic [2:0] nxt;
      case (y)
         S0:      nxt = w ? {S1, 1'b0} : {S0, 1'b0};
         S1:      nxt = w ? {S1, 1'b0} : {S2, 1'b0};
         S2:      nxt = w ? {S1, 1'b1} : {S0, 1'b0};
         default: nxt = {S0, 1'b0};
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/mealy_stream_ctrl_101_core.sv
// Bit-level Mealy datapath: flags overlapping "101" on w.
// z is combinational from the current state and w; y is registered.
module mealy_101_core
   import mealy_stream_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       clr,
   input  logic       w,
   output logic [1:0] y,
   output logic       z
);

   logic [1:0] r_y;
   logic [2:0] w_step;

   always_comb begin
      w_step = det_step(r_y, w);
   end

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         r_y <= S0;
      end else if (en) begin
         r_y <= w_step[2:1];
      end
   end

   assign y = r_y;
   assign z = w_step[0];

endmodule

// File: rtl/mealy_stream_ctrl.sv
// Serialises words MSB first into the "101" detector and reports
// the per-word match count over a valid/ready result port.
module mealy_stream_ctrl
   import mealy_stream_ctrl_pkg::*;
#(
   parameter int WORD_W = DEF_WORD_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_cont,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  out_count,
   output logic              match_pulse,
   output logic              busy
);

   localparam int BC_W = $clog2(WORD_W);
   localparam logic [BC_W-1:0]  BITS_INIT = BC_W'(WORD_W - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   ctrl_state_e       r_state;
   logic [WORD_W-1:0] r_shift;
   logic [BC_W-1:0]   r_bits;
   logic [CNT_W-1:0]  r_count;
   logic              r_in_ready;
   logic              r_out_valid;
   logic              r_busy;
   logic              r_match;

   logic       w_accept;
   logic       w_en;
   logic       w_clr;
   logic       w_bit;
   logic       w_z;
   logic [1:0] w_y;
   logic       w_unused_y;

   assign w_accept   = in_valid & r_in_ready;
   assign w_en       = (r_state == SHIFT);
   assign w_clr      = w_accept & ~in_cont;
   assign w_bit      = r_shift[WORD_W-1];
   assign w_unused_y = ^w_y;

   mealy_101_core u_core (
      .clk   (clk),
      .reset (reset),
      .en    (w_en),
      .clr   (w_clr),
      .w     (w_bit),
      .y     (w_y),
      .z     (w_z)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_shift     <= '0;
         r_bits      <= '0;
         r_count     <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_match     <= 1'b0;
      end else begin
         r_match <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_shift    <= in_data;
                  r_bits     <= BITS_INIT;
                  r_count    <= '0;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= SHIFT;
               end
            end
            SHIFT: begin
               r_match <= w_z;
               if (w_z && (r_count != CNT_MAX)) begin
                  r_count <= r_count + CNT_W'(1);
               end
               r_shift <= {r_shift[WORD_W-2:0], 1'b0};
               // Last bit consumed on the edge where the counter reads 0.
               if (r_bits == '0) begin
                  r_out_valid <= 1'b1;
                  r_state     <= REPORT;
               end else begin
                  r_bits <= r_bits - BC_W'(1);
               end
            end
            REPORT: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready    = r_in_ready;
   assign out_valid   = r_out_valid;
   assign out_count   = r_count;
   assign match_pulse = r_match;
   assign busy        = r_busy;

endmodule
